// File: rtl/enc_arb_pkg.sv
// enc_arb_pkg: shared constants and FSM state type for the encoder/decoder arbiter
package enc_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, GRANT} state_e;
endpackage

// File: rtl/rr_priority_enc.sv
// rr_priority_enc: combinational round-robin pick; in req,ptr; out any (some req set), idx (first set bit from ptr upward, mod 8)
module rr_priority_enc
  import enc_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;
  always_comb begin
    any = |req;
    idx = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ptr + IDX_W'(k);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/enc_arbiter.sv
// enc_arbiter: round-robin 8-way grant FSM with hold timeout; in clk,rst_n,req,done; out gnt,gnt_idx,gnt_valid,timeout (all registered)
module enc_arbiter
  import enc_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  localparam logic [7:0] HMAX = 8'(HOLD_MAX);
  state_e           state_q;
  logic [IDX_W-1:0] ptr_q, idx_q, win;
  logic [7:0]       hold_q;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q, timeout_q, any, max_hit, rel;
  rr_priority_enc u_enc (.req(req), .ptr(ptr_q), .any(any), .idx(win));
  assign max_hit = hold_q == HMAX;
  assign rel = done | ~req[idx_q] | max_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (any) begin
          state_q <= GRANT;
          gnt_q   <= N_REQ'(1) << win;
          idx_q   <= win;
          valid_q <= 1'b1;
          hold_q  <= '0;
        end
      end else if (rel) begin
        state_q   <= IDLE;
        gnt_q     <= '0;
        idx_q     <= '0;
        valid_q   <= 1'b0;
        ptr_q     <= idx_q + 1'b1;
        timeout_q <= max_hit & ~done & req[idx_q];
      end else begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end
  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_enc_arbiter.sv
// tb_enc_arbiter: directed table, corner sequences and randomized model check for enc_arbiter
module tb_enc_arbiter;
  localparam int HM = 4;
  logic       clk, rst_n, done, gnt_valid, timeout;
  logic [7:0] req, gnt;
  logic [2:0] gnt_idx;
  int n_pass = 0, n_total = 0;
  int m_busy, m_idx, m_ptr, m_hold, m_to;

  typedef struct packed {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;
  vec_t tv[21];

  enc_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
    chk({nm, ".gnt"}, 32'(gnt), 32'(g));
    chk({nm, ".gnt_idx"}, 32'(gnt_idx), 32'(i));
    chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
    chk({nm, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req = 0;
    done = 0;
    #1;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  // Behavioural reference: applies one clock edge with the inputs seen before it.
  task automatic model_edge(input logic [7:0] r, input logic d);
    if (m_busy == 0) begin
      m_to = 0;
      for (int k = 0; k < 8; k++)
        if (r[(m_ptr + k) % 8]) begin
          m_idx = (m_ptr + k) % 8; m_busy = 1; m_hold = 0;
          break;
        end
    end else if (d || !r[m_idx] || m_hold == HM) begin
      m_to = (!d && r[m_idx]) ? 1 : 0;
      m_busy = 0;
      m_ptr = (m_idx + 1) % 8;
    end else begin
      m_hold++;
      m_to = 0;
    end
  endtask

  initial begin
    tv[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tv[1]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tv[2]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tv[3]  = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[4]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[5]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[6]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[7]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[8]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[9]  = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
    tv[10] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[11] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[12] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[13] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[14] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    tv[15] = '{8'h10, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[16] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[17] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    tv[18] = '{8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[19] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    tv[20] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      req = tv[i].req;
      done = tv[i].done;
      step();
      chk_out($sformatf("vec%0d", i), tv[i].gnt, tv[i].idx, tv[i].vld, tv[i].to);
    end

    do_reset();
    req = 8'hFF;
    done = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rr%0d.idx", k), 32'(gnt_idx), 32'(k % 8));
      chk($sformatf("rr%0d.valid", k), 32'(gnt_valid), 32'd1);
      step();
      chk($sformatf("rr%0d.gap", k), 32'(gnt_valid), 32'd0);
    end

    do_reset();
    req = 8'h04;
    done = 0;
    step();
    chk("async.pre_idx", 32'(gnt_idx), 32'd2);
    #2;
    rst_n = 0;
    #1;
    chk_out("async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    req = 8'h80;
    step();
    chk_out("async.after", 8'h80, 3'd7, 1'b1, 1'b0);

    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      logic d;
      case ($urandom_range(0, 3))
        0: r = 8'h00;
        1: r = 8'h01 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      d = ($urandom_range(0, 4) == 0);
      if (c % 50 < 12) r = 8'hFF;
      req = r;
      done = d;
      step();
      model_edge(r, d);
      chk_out($sformatf("rand%0d", c), m_busy ? 8'(1 << m_idx) : 8'h00,
              m_busy ? 3'(m_idx) : 3'd0, 1'(m_busy), 1'(m_to));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
